sram_controller: RTL
====================

# sram_controller

Responder side of the MEM-stage memory interface. It accepts the read/write requests, word address and store data the MEM stage issues. It performs each 32-bit access as two sequential 16-bit accesses on an external single-port SRAM. It holds `ready` low until the access completes, and the hazard/freeze logic uses `ready` to stall the pipeline. The block replaces the single-cycle behavioural memory behind the MEM stage.

## Interface
Parameters:
- `ACCESS_CYCLES`, 2: clocks each 16-bit half-access occupies (≥1).
- `BASE_ADDR`, 1024: byte address mapped to SRAM halfword 0.
- `SRAM_AW`, 18: SRAM halfword-address width.

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: synchronous, active-low reset.
- `MEM_R_EN` in 1: load request.
- `MEM_W_EN` in 1: store request.
- `ALU_res` in 32: byte address (word-aligned).
- `Val_Rm` in 32: store data.
- `MEM_out` out 32: load data, registered.
- `ready` out 1: high when no access is pending or the current access is complete.
- `sram_addr` out SRAM_AW: halfword address.
- `sram_dq_out` out 16: write data to SRAM.
- `sram_dq_oe` out 1: data bus drive enable (top level builds the tristate).
- `sram_dq_in` in 16: read data from SRAM.
- `sram_we_n` out 1: active-low write enable.

## Operation
- FSM states:
  - IDLE → LOW on a request (`MEM_R_EN | MEM_W_EN`).
  - LOW → HIGH after ACCESS_CYCLES clocks.
  - HIGH → DONE after ACCESS_CYCLES clocks.
  - DONE → IDLE unconditionally.
- Request latch:
  - Op, address and store data are latched on the IDLE→LOW transition.
  - Inputs are ignored after that until IDLE.
- Write priority: if both enables are high, the access is a write.
- Address arithmetic:
  - `word = (ALU_res - BASE_ADDR) >> 2`, truncated to SRAM_AW-1 bits.
  - LOW phase: `sram_addr = {word, 1'b0}`. HIGH phase: `sram_addr = {word, 1'b1}`.
  - Addresses outside the window wrap modulo 2^(SRAM_AW-1) words; no error is flagged.
- Write:
  - LOW phase: `sram_dq_out = data[15:0]`. HIGH phase: `sram_dq_out = data[31:16]`.
  - `sram_we_n = 0` and `sram_dq_oe = 1` on every LOW/HIGH cycle.
- Read:
  - `sram_we_n = 1`, `sram_dq_oe = 0`.
  - `MEM_out[15:0]` captures `sram_dq_in` on the last LOW cycle.
  - `MEM_out[31:16]` captures it on the last HIGH cycle.
  - A write leaves `MEM_out` unchanged.
- `ready` (combinational) = `(state==IDLE & ~(MEM_R_EN|MEM_W_EN)) | state==DONE`.
- Outside LOW/HIGH, and after any reset:
  - `sram_we_n = 1`, `sram_dq_oe = 0`.
  - `sram_addr` and `sram_dq_out` are don't-care, driven 0.

## Timing
- Reset (`rst = 0` at an edge):
  - state = IDLE, `MEM_out = 0`, phase counter = 0.
  - `sram_we_n = 1`, `sram_dq_oe = 0`, `sram_addr = 0`, `sram_dq_out = 0`.
  - `ready` follows the combinational rule above.
- Reset mid-access aborts the access. A partially written word is left as-is in SRAM.
- Request seen in IDLE at cycle 0:
  - `ready` is low in the same cycle and stays low for 1 + 2·ACCESS_CYCLES cycles.
  - `ready` is high in DONE, at cycle 1 + 2·ACCESS_CYCLES (cycle 5 at the default).
- In DONE the pipeline advances, and `MEM_out` is valid and stable.
- A request present in the cycle after DONE (IDLE) starts a new access immediately.
  - No IDLE bubble is required beyond that one cycle.
- Requests held high through DONE belong to the completing instruction. Only the IDLE sample starts a new access.
- `sram_dq_in` is sampled at the rising edge ending each phase. The SRAM must present data within ACCESS_CYCLES clocks of the address change.

## Structure
- Package `mem_pkg`:
  - state enum (IDLE, LOW, HIGH, DONE).
  - default BASE_ADDR and SRAM_AW constants.
  - the shared MEM-stage address/data widths.
- Single RTL module; the phase counter is inline.
- `sram_model` (behavioural, testbench-only) models the external 16-bit SRAM with programmable read latency.

## Test plan
- Reset: hold `rst = 0` for 3 cycles with `MEM_W_EN = 1` → `sram_we_n = 1`, `sram_dq_oe = 0`, `MEM_out = 0`. With enables low, `ready = 1`.
- Store `Val_Rm = 0xDEADBEEF` at `ALU_res = 1028`:
  - `sram_addr = 2` with data `0xBEEF` for 2 cycles, then `sram_addr = 3` with data `0xDEAD` for 2 cycles.
  - `ready` is low for 5 cycles, then high for 1.
- Load from 1028 after that store → `MEM_out = 0xDEADBEEF` in DONE, and `sram_we_n` stays 1 throughout.
- Back-to-back: a store and then a load on consecutive instructions → the second access starts in the IDLE cycle after DONE, and neither access is dropped.
- Both enables high with address 1032 → the access is performed as a write to halfwords 4/5.
- Assert `rst` during the HIGH phase of a load → the next cycle is IDLE, `MEM_out = 0`, and `sram_we_n = 1`. A subsequent load completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared MEM-stage widths, SRAM defaults and the access FSM state type
// for the two-halfword SRAM controller.
package mem_pkg;
   localparam int MEM_AW  = 32;
   localparam int MEM_DW  = 32;
   localparam int SRAM_DW = 16;

   localparam logic [MEM_AW-1:0] DEFAULT_BASE_ADDR = 32'd1024;
   localparam int                DEFAULT_SRAM_AW   = 18;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_e;
endpackage

// File: rtl/sram_controller.sv
// MEM-stage responder: performs each 32-bit load/store as two 16-bit
// accesses on a single-port SRAM, holding ready low until the word completes.
module sram_controller
   import mem_pkg::*;
#(
   parameter int                ACCESS_CYCLES = 2,
   parameter logic [MEM_AW-1:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
   parameter int                SRAM_AW       = DEFAULT_SRAM_AW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               MEM_R_EN,
   input  logic               MEM_W_EN,
   input  logic [MEM_AW-1:0]  ALU_res,
   input  logic [MEM_DW-1:0]  Val_Rm,
   output logic [MEM_DW-1:0]  MEM_out,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [SRAM_DW-1:0] sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [SRAM_DW-1:0] sram_dq_in,
   output logic               sram_we_n
);
   localparam int            CW       = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);
   localparam int            WW       = SRAM_AW - 1;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              is_write_q, is_write_d;
   logic [WW-1:0]     word_q, word_d;
   logic [MEM_DW-1:0] data_q, data_d;
   logic [MEM_DW-1:0] mem_out_q, mem_out_d;

   logic req;
   logic phase_last;
   logic in_phase;
   logic high_phase;

   assign req        = MEM_R_EN | MEM_W_EN;
   assign phase_last = (cnt_q == CNT_LAST);
   assign in_phase   = (state_q == LOW) || (state_q == HIGH);
   assign high_phase = (state_q == HIGH);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_write_d = is_write_q;
      word_d     = word_q;
      data_d     = data_q;
      mem_out_d  = mem_out_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d    = LOW;
               cnt_d      = '0;
               is_write_d = MEM_W_EN;
               // Out-of-window addresses simply wrap within the SRAM.
               word_d     = WW'((ALU_res - BASE_ADDR) >> 2);
               data_d     = Val_Rm;
            end
         end
         LOW, HIGH: begin
            if (phase_last) begin
               cnt_d   = '0;
               state_d = high_phase ? DONE : HIGH;
               if (!is_write_q) begin
                  if (high_phase) mem_out_d[31:16] = sram_dq_in;
                  else            mem_out_d[15:0]  = sram_dq_in;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready       = ((state_q == IDLE) && !req) || (state_q == DONE);
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_we_n   = 1'b1;
      sram_dq_oe  = 1'b0;
      if (in_phase) begin
         sram_addr = {word_q, high_phase};
         if (is_write_q) begin
            sram_we_n   = 1'b0;
            sram_dq_oe  = 1'b1;
            sram_dq_out = high_phase ? data_q[31:16] : data_q[15:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         is_write_q <= 1'b0;
         word_q     <= '0;
         data_q     <= '0;
         mem_out_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_write_q <= is_write_d;
         word_q     <= word_d;
         data_q     <= data_d;
         mem_out_q  <= mem_out_d;
      end
   end

   assign MEM_out = mem_out_q;
endmodule
